// File: rtl/shift_reg_word_loader_pkg.sv
// ============================================================================
// Module      : shift_reg_word_loader_pkg
// Description : Shared types and direction constants for the word loader and
//               the downstream bidirectional shift register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_reg_word_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic DIR_TO_MSB = 1'b0;
   localparam logic DIR_TO_LSB = 1'b1;

   // Word bit sent at a given shift step; chosen so the register ends up
   // holding the word unchanged after MSB shifts in the given direction.
   function automatic int bit_index(input int msb, input int step, input logic dir);
      return (dir == DIR_TO_LSB) ? step : (msb - 1 - step);
   endfunction

endpackage

`default_nettype wire

// File: rtl/shift_reg_word_loader.sv
// ============================================================================
// Module      : shift_reg_word_loader
// Description : Parallel-to-serial loader driving a bidirectional shift
//               register one bit per cycle, with valid/ready word intake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_word_loader
   import shift_reg_word_loader_pkg::*;
#(
   parameter int MSB = 4
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [MSB-1:0] in_data,
   input  logic           in_dir,
   input  logic           stall,
   output logic           sr_d,
   output logic           sr_en,
   output logic           sr_dir,
   output logic           word_done,
   output logic           busy
);

   localparam int              CNT_W    = $clog2(MSB);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSB - 1);

   state_e           state_q,   state_d;
   logic [MSB-1:0]   word_q,    word_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             dir_q,     dir_d;
   logic             sr_d_q,    sr_d_d;
   logic             sr_dir_q,  sr_dir_d;
   logic             ready_q,   ready_d;
   logic             done_q,    done_d;
   logic             busy_q,    busy_d;

   logic             xfer;
   logic             step;
   logic [CNT_W-1:0] first_idx;
   logic [CNT_W-1:0] next_idx;

   always_comb begin
      xfer      = in_valid && ready_q;
      step      = (state_q == SHIFT) && !stall;
      first_idx = CNT_W'(bit_index(MSB, 0, in_dir));
      next_idx  = CNT_W'(bit_index(MSB, int'(cnt_q) + 1, dir_q));

      state_d = state_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      sr_d_d  = sr_d_q;

      case (state_q)
         IDLE, DONE: begin
            if (xfer) begin
               state_d = SHIFT;
               word_d  = in_data;
               dir_d   = in_dir;
               cnt_d   = '0;
               sr_d_d  = in_data[first_idx];
            end else begin
               state_d = IDLE;
               sr_d_d  = 1'b0;
            end
         end
         SHIFT: begin
            if (step) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
                  sr_d_d  = 1'b0;
               end else begin
                  cnt_d  = cnt_q + CNT_W'(1);
                  sr_d_d = word_q[next_idx];
               end
            end
         end
         default: begin
            state_d = IDLE;
            sr_d_d  = 1'b0;
         end
      endcase

      // Outputs are registered from the next state so they align with it.
      ready_d  = (state_d != SHIFT);
      done_d   = (state_d == DONE);
      busy_d   = (state_d == SHIFT);
      sr_dir_d = (state_d == IDLE) ? 1'b0 : dir_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         word_q   <= '0;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         sr_d_q   <= 1'b0;
         sr_dir_q <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         sr_d_q   <= sr_d_d;
         sr_dir_q <= sr_dir_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   // Enable must drop in the same cycle stall rises, so it bypasses the flops.
   assign sr_en     = (state_q == SHIFT) && !stall;
   assign sr_d      = sr_d_q;
   assign sr_dir    = sr_dir_q;
   assign in_ready  = ready_q;
   assign word_done = done_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire
